// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage sequencer for the data-memory port. Issues word read/write
// requests to a variable-latency memory over a req/ready handshake, stalls
// the whole pipeline while a transfer is outstanding, aborts transfers that
// wait longer than TIMEOUT request cycles and flags misaligned addresses.
//
// Parameters
//   TIMEOUT          maximum number of cycles mem_req may stay high without
//                    mem_ready before the access is aborted (>= 2)
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   mem_read_M       MEM-stage instruction is a load
//   mem_write_M      MEM-stage instruction is a store (wins if both set)
//   ALU_result_M     byte address of the access
//   write_data_M     store data
//   mem_ready        memory completes the transfer this cycle
//   mem_rdata        memory read data, valid with mem_ready
//   mem_req          request to memory
//   mem_we           1 = write, 0 = read; valid with mem_req
//   mem_addr         word-aligned address; valid with mem_req
//   mem_wdata        store data; valid with mem_req & mem_we
//   mem_read_data_M  load data for the MEM_WB register
//   stall_F..stall_W hold the pipeline registers (all equal)
//   align_error      sticky: a misaligned access was seen
//   bus_error        sticky: an access timed out
//   access_count     completed transfers (wraps)
//   stall_count      cycles with stall asserted (wraps)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read_M,
    input  logic        mem_write_M,
    input  logic [31:0] ALU_result_M,
    input  logic [31:0] write_data_M,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_read_data_M,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        stall_W,
    output logic        align_error,
    output logic        bus_error,
    output logic [31:0] access_count,
    output logic [31:0] stall_count
);

    // wait_cnt only has to reach TIMEOUT-2, so clog2(TIMEOUT) bits suffice.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  wait_cnt_reg;
    logic [31:0]    addr_reg;
    logic [31:0]    wdata_reg;
    logic           we_reg;
    logic           align_error_reg;
    logic           bus_error_reg;
    logic [31:0]    access_count_reg;
    logic [31:0]    stall_count_reg;

    logic           access;
    logic           misaligned;
    logic           req_int;
    logic           stall_int;
    logic           complete;
    logic           we_int;
    logic [31:0]    addr_int;
    logic [31:0]    wdata_int;

    assign access     = mem_read_M | mem_write_M;
    assign misaligned = |ALU_result_M[1:0];

    // Request, stall and completion are combinational so a zero-wait memory
    // finishes in the issuing cycle and the pipeline sees the stall on the
    // same edge it would otherwise advance.
    always_comb begin
        req_int   = 1'b0;
        stall_int = 1'b0;
        complete  = 1'b0;
        we_int    = mem_write_M;
        addr_int  = {ALU_result_M[31:2], 2'b00};
        wdata_int = write_data_M;
        case (state_reg)
            ST_IDLE: begin
                if (access && !misaligned) begin
                    req_int   = 1'b1;
                    complete  = mem_ready;
                    stall_int = !mem_ready;
                end
            end
            ST_WAIT: begin
                // Drive from the latched copy: the stalled MEM stage still
                // holds the same instruction, but the latch makes the bus
                // independent of anything upstream.
                req_int   = 1'b1;
                we_int    = we_reg;
                addr_int  = addr_reg;
                wdata_int = wdata_reg;
                complete  = mem_ready;
                stall_int = !mem_ready;
            end
            default: begin
                // ABORT: no request, no stall, mem_ready ignored.
            end
        endcase
    end

    // reset is folded in so that pulling it low drops the request and the
    // stalls immediately, without waiting for the state register to settle.
    assign mem_req         = reset & req_int;
    assign mem_we          = we_int;
    assign mem_addr        = addr_int;
    assign mem_wdata       = wdata_int;
    assign mem_read_data_M = (reset && complete && !we_int) ? mem_rdata : 32'd0;

    assign stall_F = reset & stall_int;
    assign stall_D = reset & stall_int;
    assign stall_E = reset & stall_int;
    assign stall_M = reset & stall_int;
    assign stall_W = reset & stall_int;

    assign align_error  = align_error_reg;
    assign bus_error    = bus_error_reg;
    assign access_count = access_count_reg;
    assign stall_count  = stall_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            wait_cnt_reg     <= '0;
            addr_reg         <= 32'd0;
            wdata_reg        <= 32'd0;
            we_reg           <= 1'b0;
            align_error_reg  <= 1'b0;
            bus_error_reg    <= 1'b0;
            access_count_reg <= 32'd0;
            stall_count_reg  <= 32'd0;
        end else begin
            if (complete) begin
                access_count_reg <= access_count_reg + 32'd1;
            end
            if (stall_int) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            align_error_reg <= 1'b1;
                        end else if (!mem_ready) begin
                            addr_reg     <= addr_int;
                            wdata_reg    <= write_data_M;
                            we_reg       <= mem_write_M;
                            wait_cnt_reg <= '0;
                            state_reg    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Ready in the last allowed cycle still wins over abort.
                    if (mem_ready) begin
                        state_reg <= ST_IDLE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= ST_ABORT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_ABORT: begin
                    bus_error_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the data-memory port in the MEM stage. It issues word read/write requests to a variable-latency data memory over a req/ready handshake, and stalls the whole pipeline while a transfer is outstanding. It aborts transfers that exceed a timeout and flags misaligned addresses. It feeds read data to the MEM_WB register and drives the per-stage stall lines (stall_F … stall_W).

## Interface
- TIMEOUT, 16: maximum number of cycles mem_req may stay high without mem_ready before the access is aborted (≥2).

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_read_M  in  1  MEM-stage instruction is a load
- mem_write_M  in  1  MEM-stage instruction is a store (wins if both set)
- ALU_result_M  in  32  byte address of the access
- write_data_M  in  32  store data
- mem_ready  in  1  memory completes the transfer this cycle
- mem_rdata  in  32  memory read data, valid when mem_ready
- mem_req  out  1  request to memory
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  32  word-aligned address; valid with mem_req
- mem_wdata  out  32  store data; valid with mem_req & mem_we
- mem_read_data_M  out  32  load data for MEM_WB
- stall_F, stall_D, stall_E, stall_M, stall_W  out  1 each  hold the corresponding pipeline register (all equal)
- align_error  out  1  sticky: a misaligned access was seen
- bus_error  out  1  sticky: an access timed out
- access_count  out  32  completed transfers, wraps
- stall_count  out  32  cycles with stall asserted, wraps

## Operation
- The access signal is mem_read_M | mem_write_M. An access is misaligned when ALU_result_M[1:0] ≠ 0.
- State IDLE:
  - Access and aligned: mem_req=1 combinationally.
  - mem_ready=1 the same cycle: the transfer completes and there is no stall.
  - Otherwise: stall=1. Latch the address, data and we. Clear wait_cnt. Go to WAIT.
  - Access and misaligned: no request, no stall. Set align_error. mem_read_data_M=0.
- State WAIT:
  - mem_req=1, driven from the latched address, data and we.
  - mem_ready=1: complete, stall=0, go to IDLE.
  - Else if wait_cnt==TIMEOUT-2: go to ABORT with stall=1.
  - Else: wait_cnt+1, stall=1.
- State ABORT (one cycle):
  - mem_req=0, stall=0. Set bus_error. mem_read_data_M=0. mem_ready is ignored. Go to IDLE.
- In the completing cycle:
  - mem_read_data_M = mem_rdata (pass-through) for reads and 0 for writes.
  - access_count increments.
- In all other cycles mem_read_data_M = 0.
- stall_count increments on every cycle with stall=1.
- mem_we = mem_write_M (latched in WAIT). mem_addr is {addr[31:2],2'b00}.
- align_error and bus_error are cleared only by reset.
- mem_req and the stalls are forced to 0 while reset is low.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, wait_cnt=0.
  - align_error=0, bus_error=0, access_count=0, stall_count=0.
  - mem_req=0, all stalls=0, mem_read_data_M=0.
- Reset mid-WAIT drops mem_req in the same cycle. The memory must tolerate an abandoned request.
- Latency, with the request issued in cycle N (IDLE):
  - Zero-wait memory: 0 stall cycles; MEM_WB captures the data at the end of cycle N.
  - Ready in cycle N+k (k ≤ TIMEOUT-1): k stall cycles.
- Timeout:
  - mem_req is high for exactly TIMEOUT cycles (N … N+TIMEOUT-1).
  - Cycle N+TIMEOUT is ABORT, with no stall.
  - Total stall cycles = TIMEOUT.
- mem_ready arriving in the same cycle that would otherwise trigger ABORT counts as completion.
- Stalls are combinational from state and mem_ready. The pipeline registers capture on the same edge.
- Back-to-back accesses:
  - A new access can be issued in the IDLE cycle right after completion or abort.
  - There is no dead cycle after completion. ABORT costs one non-stalled cycle with no request.

## Test plan
- Zero-wait load:
  - Stimulus: mem_read_M=1, addr 0x100, mem_ready=1, mem_rdata=0xCAFEF00D.
  - Response: mem_req=1, no stall, mem_read_data_M=0xCAFEF00D, access_count=1.
- 3-wait store:
  - Stimulus: mem_write_M=1, addr 0x204, data 0x12345678, mem_ready on the 4th request cycle.
  - Response: stall high for exactly 3 cycles. mem_addr/mem_wdata/mem_we stable at 0x204/0x12345678/1 throughout. stall_count=3, access_count=1.
- Timeout:
  - Stimulus: TIMEOUT=16, load with mem_ready held 0.
  - Response: mem_req high 16 cycles, stall high 16 cycles, then one ABORT cycle with mem_req=0, stall=0, bus_error=1. A following zero-wait load completes normally.
- Misaligned:
  - Stimulus: load at 0x102.
  - Response: mem_req=0, no stall, align_error=1, mem_read_data_M=0, access_count unchanged.
- Reset mid-WAIT:
  - Stimulus: pull reset low 2 cycles into a wait.
  - Response: mem_req and stalls go to 0 immediately; counters and flags are 0. After release, a fresh load at 0x8 with ready completes.
- Boundary:
  - Stimulus: mem_ready first asserted in the 16th request cycle (TIMEOUT=16).
  - Response: completion, bus_error stays 0, 15 stall cycles.
